// File: rtl/motor_ramp_ctrl_if.sv
// Command handshake between a motion sequencer (master) and motor_ramp_ctrl (slave).
interface motor_ramp_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_level;
  logic       cmd_dir;

  modport master (output cmd_valid, output cmd_level, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_level, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Ramps the motor drive level one step per pwm period toward a commanded target and
// inserts a zero-output brake dwell before any direction reversal.
module motor_ramp_ctrl #(
  parameter int STEP_CYCLES  = 256,
  parameter int BRAKE_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  motor_ramp_ctrl_if.slave      cmd,
  input  logic                  estop,
  output logic [1:0]            speed,
  output logic                  motor_en,
  output logic                  dir,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DOWN, BRAKE, HOLD} state_t;

  localparam logic [15:0] STEP_LAST  = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] BRAKE_LAST = 16'(BRAKE_CYCLES - 1);

  state_t      state;
  logic [2:0]  lvl;
  logic [2:0]  tgt_lvl;
  logic        tgt_dir;
  logic        rev_pending;
  logic [15:0] timer;

  logic [2:0]  cmd_sat;
  logic [2:0]  lvl_up;
  logic [2:0]  lvl_dn;
  logic [2:0]  lvl_m1;
  logic [2:0]  down_floor;
  logic        ready_core;
  logic        accept;
  logic        step_due;

  assign cmd_sat    = (cmd.cmd_level > 3'd4) ? 3'd4 : cmd.cmd_level;
  assign ready_core = !estop && (state == IDLE || state == HOLD);
  assign cmd.cmd_ready = rst && ready_core;
  assign accept     = cmd.cmd_valid && ready_core;
  assign lvl_up     = (lvl < 3'd4) ? lvl + 3'd1 : lvl;
  assign lvl_dn     = (lvl > 3'd0) ? lvl - 3'd1 : lvl;
  // A pending reversal always ramps all the way to zero before the brake dwell.
  assign down_floor = rev_pending ? 3'd0 : tgt_lvl;
  assign step_due   = (timer == STEP_LAST);

  assign lvl_m1   = lvl - 3'd1;
  assign speed    = (lvl != 3'd0) ? lvl_m1[1:0] : 2'd0;
  assign motor_en = (lvl != 3'd0);
  assign busy     = !(state == IDLE || state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lvl         <= 3'd0;
      dir         <= 1'b0;
      tgt_lvl     <= 3'd0;
      tgt_dir     <= 1'b0;
      rev_pending <= 1'b0;
      timer       <= 16'd0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (estop) begin
        state       <= IDLE;
        lvl         <= 3'd0;
        timer       <= 16'd0;
        rev_pending <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (accept) begin
              tgt_lvl <= cmd_sat;
              tgt_dir <= cmd.cmd_dir;
              timer   <= 16'd0;
              if (cmd.cmd_dir != dir && lvl != 3'd0) begin
                state       <= RAMP_DOWN;
                rev_pending <= 1'b1;
              end else if (cmd.cmd_dir != dir) begin
                // Already stopped, so the reversal needs no brake dwell.
                dir <= cmd.cmd_dir;
                if (cmd_sat != 3'd0) begin
                  state <= RAMP_UP;
                end else begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              end else if (cmd_sat > lvl) begin
                state <= RAMP_UP;
              end else if (cmd_sat < lvl) begin
                state <= RAMP_DOWN;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RAMP_UP: begin
            if (step_due) begin
              timer <= 16'd0;
              lvl   <= lvl_up;
              if (lvl_up >= tgt_lvl) begin
                state <= HOLD;
                done  <= 1'b1;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          RAMP_DOWN: begin
            if (step_due) begin
              timer <= 16'd0;
              lvl   <= lvl_dn;
              if (lvl_dn <= down_floor) begin
                if (rev_pending) begin
                  state <= BRAKE;
                end else begin
                  state <= (lvl_dn == 3'd0) ? IDLE : HOLD;
                  done  <= 1'b1;
                end
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          BRAKE: begin
            if (timer == BRAKE_LAST) begin
              timer       <= 16'd0;
              dir         <= tgt_dir;
              rev_pending <= 1'b0;
              if (tgt_lvl != 3'd0) begin
                state <= RAMP_UP;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scenario bench for motor_ramp_ctrl: each accepted command is expanded into a per-cycle
// trajectory (ramp segments, brake dwell, direction flip) that the outputs must follow.
module tb_motor_ramp_ctrl;
  localparam int STEP  = 4;
  localparam int BRAKE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       estop = 1'b0;
  logic [1:0] speed;
  logic       motor_en;
  logic       dir;
  logic       busy;
  logic       done;

  motor_ramp_ctrl_if cmd();

  motor_ramp_ctrl #(.STEP_CYCLES(STEP), .BRAKE_CYCLES(BRAKE)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .estop    (estop),
    .speed    (speed),
    .motor_en (motor_en),
    .dir      (dir),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    bit dir;
    bit done;
    bit busy;
  } entry_t;

  entry_t plan[$];
  int     errors = 0;
  int     checks = 0;
  int     m_lvl  = 0;
  bit     m_dir  = 1'b0;

  function automatic void push(int l, bit d, bit dn, bit b);
    entry_t e;
    e.lvl  = l;
    e.dir  = d;
    e.done = dn;
    e.busy = b;
    plan.push_back(e);
  endfunction

  // Each level change takes one full step period; the last change of a final ramp pulses done.
  function automatic void ramp(int from, int to, bit d, bit final_target);
    int cur = from;
    while (cur != to) begin
      bit last;
      repeat (STEP - 1) push(cur, d, 1'b0, 1'b1);
      cur  = (to > cur) ? cur + 1 : cur - 1;
      last = (cur == to) && final_target;
      push(cur, d, last, !last);
    end
  endfunction

  // Entry i holds the expected outputs after the i-th edge following the accept edge.
  function automatic void build_plan(int cur, bit cdir, int raw, bit tdir);
    int t = (raw > 4) ? 4 : raw;
    plan.delete();
    if (tdir != cdir && cur > 0) begin
      push(cur, cdir, 1'b0, 1'b1);
      ramp(cur, 0, cdir, 1'b0);
      repeat (BRAKE - 1) push(0, cdir, 1'b0, 1'b1);
      if (t > 0) begin
        push(0, tdir, 1'b0, 1'b1);
        ramp(0, t, tdir, 1'b1);
      end else begin
        push(0, tdir, 1'b1, 1'b0);
      end
    end else if (t == cur) begin
      push(cur, tdir, 1'b1, 1'b0);
    end else begin
      push(cur, tdir, 1'b0, 1'b1);
      ramp(cur, t, tdir, 1'b1);
    end
  endfunction

  task automatic run_command(input int level, input bit d, input int stop_at,
                             input bit hold_valid, input int next_level, input bit next_dir);
    build_plan(m_lvl, m_dir, level, d);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_level = 3'(level);
    cmd.cmd_dir   = d;
    #1;
    checks++;
    if (cmd.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_ready lvl=%0d: got %b expected 1", level, cmd.cmd_ready);
    end
    @(posedge clk);
    for (int i = 0; i < plan.size(); i++) begin
      logic [1:0] exp_speed;
      @(negedge clk);
      exp_speed = (plan[i].lvl > 0) ? 2'(plan[i].lvl - 1) : 2'd0;
      checks += 6;
      if (speed !== exp_speed) begin
        errors++;
        $display("[TB] FAIL speed step %0d: got %0d expected %0d", i, speed, exp_speed);
      end
      if (motor_en !== (plan[i].lvl != 0)) begin
        errors++;
        $display("[TB] FAIL motor_en step %0d: got %b expected %b", i, motor_en, plan[i].lvl != 0);
      end
      if (dir !== plan[i].dir) begin
        errors++;
        $display("[TB] FAIL dir step %0d: got %b expected %b", i, dir, plan[i].dir);
      end
      if (done !== plan[i].done) begin
        errors++;
        $display("[TB] FAIL done step %0d: got %b expected %b", i, done, plan[i].done);
      end
      if (busy !== plan[i].busy) begin
        errors++;
        $display("[TB] FAIL busy step %0d: got %b expected %b", i, busy, plan[i].busy);
      end
      if (cmd.cmd_ready !== !plan[i].busy) begin
        errors++;
        $display("[TB] FAIL cmd_ready step %0d: got %b expected %b", i, cmd.cmd_ready, !plan[i].busy);
      end
      m_lvl = plan[i].lvl;
      m_dir = plan[i].dir;
      if (i == 0) begin
        if (hold_valid) begin
          cmd.cmd_level = 3'(next_level);
          cmd.cmd_dir   = next_dir;
        end else begin
          cmd.cmd_valid = 1'b0;
        end
      end
      if (stop_at >= 0 && i == stop_at) break;
    end
  endtask

  task automatic test_reset();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_level = 3'd4;
    cmd.cmd_dir   = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks += 5;
      if (motor_en !== 1'b0 || speed !== 2'd0) begin
        errors++;
        $display("[TB] FAIL reset_drive cycle %0d: got en=%b speed=%0d expected 0", k, motor_en, speed);
      end
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", k, busy);
      end
      if (cmd.cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready cycle %0d: got %b expected 0", k, cmd.cmd_ready);
      end
      if (dir !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_dir cycle %0d: got %b expected 0", k, dir);
      end
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_done cycle %0d: got %b expected 0", k, done);
      end
      @(negedge clk);
    end
    cmd.cmd_valid = 1'b0;
    rst   = 1'b1;
    m_lvl = 0;
    m_dir = 1'b0;
  endtask

  task automatic test_ramp_up();
    run_command(4, 1'b0, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reversal();
    run_command(2, 1'b1, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_same_level();
    run_command(3, m_dir, -1, 1'b0, 0, 1'b0);
    run_command(3, m_dir, -1, 1'b0, 0, 1'b0);
    run_command(7, m_dir, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_estop();
    bit held_dir;
    run_command(0, m_dir, -1, 1'b0, 0, 1'b0);
    run_command(4, m_dir, 2 * STEP + 1, 1'b0, 0, 1'b0);
    held_dir      = m_dir;
    estop         = 1'b1;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_level = 3'd4;
    cmd.cmd_dir   = !held_dir;
    #1;
    checks++;
    if (cmd.cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL estop_ready: got %b expected 0", cmd.cmd_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks += 4;
      if (motor_en !== 1'b0 || speed !== 2'd0) begin
        errors++;
        $display("[TB] FAIL estop_drive cycle %0d: got en=%b speed=%0d expected 0", k, motor_en, speed);
      end
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL estop_busy cycle %0d: got %b expected 0", k, busy);
      end
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL estop_done cycle %0d: got %b expected 0", k, done);
      end
      if (dir !== held_dir) begin
        errors++;
        $display("[TB] FAIL estop_dir cycle %0d: got %b expected %b", k, dir, held_dir);
      end
    end
    estop         = 1'b0;
    cmd.cmd_valid = 1'b0;
    m_lvl         = 0;
    run_command(3, m_dir, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_in_brake();
    run_command(3, 1'b1, -1, 1'b0, 0, 1'b0);
    run_command(2, 1'b0, 3 * STEP + 3, 1'b0, 0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (dir !== 1'b0) begin
      errors++;
      $display("[TB] FAIL brake_reset_dir: got %b expected 0", dir);
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL brake_reset_status: got busy=%b done=%b expected 0", busy, done);
    end
    if (cmd.cmd_ready !== 1'b0 || motor_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL brake_reset_out: got ready=%b en=%b expected 0", cmd.cmd_ready, motor_en);
    end
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    m_lvl = 0;
    m_dir = 1'b0;
    run_command(1, 1'b1, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_command(4, m_dir, -1, 1'b1, 1, !m_dir);
    run_command(1, m_dir ^ 1'b1, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    int l = int'($urandom_range(0, 7));
    bit d = 1'($urandom_range(0, 1));
    for (int k = 0; k < 25; k++) begin
      int nl   = int'($urandom_range(0, 7));
      bit nd   = 1'($urandom_range(0, 1));
      bit hold = (k < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_command(l, d, -1, hold, nl, nd);
      l = nl;
      d = nd;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_level = 3'd0;
    cmd.cmd_dir   = 1'b0;
    test_reset();
    test_ramp_up();
    test_reversal();
    test_same_level();
    test_estop();
    test_reset_in_brake();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
